countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The module SHALL have exactly one clock, clk, and one reset, rst; rst SHALL be synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates SHALL occur on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 D  input  4  BCD digit from the keypad encoder; values 10-15 are invalid.
REQ-005 loadn  input  1  active-low digit-valid level from the keypad encoder, held low while a key is held.
REQ-006 pgt_1Hz  input  1  1 Hz tick from the keypad encoder; the rising edge marks one second.
REQ-007 run  input  1  high means count mode, low means entry mode.
REQ-008 sec_ones, sec_tens, min_ones, min_tens  output  4 each  BCD time digits, MM:SS.
REQ-009 zero  output  1  high when all four digits are 0.
REQ-010 done  output  1  one-cycle pulse when a countdown reaches 00:00.

Function
REQ-011 The module SHALL register loadn into loadn_q, reset value 1, and define key_evt = (loadn==0 && loadn_q==1).
REQ-012 The module SHALL register pgt_1Hz into tick_q, reset value 0, and define tick_evt = (pgt_1Hz==1 && tick_q==0).
REQ-013 Entry mode (run=0), key_evt with D<=9: SHALL shift the digits left as min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D, on the same edge.
REQ-014 Key_evt with D>9 SHALL leave all digits unchanged.
REQ-015 A key held low for many cycles SHALL load exactly one digit; another digit SHALL load only after loadn returns high for at least one cycle.
REQ-016 Entry mode: tick_evt SHALL be ignored.
REQ-017 Count mode (run=1): key_evt SHALL be ignored.
REQ-018 Count mode, tick_evt with zero=0: SHALL decrement the time by one second on that edge, per REQ-019 to REQ-022.
REQ-019 Decrement, sec_ones>0: sec_ones-1.
REQ-020 Decrement, sec_ones==0: sec_ones<=9, and sec_tens borrows.
REQ-021 sec_tens borrow: if sec_tens>0 then sec_tens-1; else sec_tens<=5 and min_ones borrows.
REQ-022 min_ones borrow: if min_ones>0 then min_ones-1; else min_ones<=9 and min_tens-1.
REQ-023 Entered sec_tens values 6-9 SHALL be kept and decremented with the normal BCD rules (e.g. 00:90 -> 00:89), not normalised.
REQ-024 Count mode, tick_evt with zero=1: SHALL hold 00:00, never wrap to 99:59, and not assert done.
REQ-025 done SHALL be registered and asserted for exactly one cycle, on the edge following the decrement that produces 00:00 (the cycle after the digits first read 00:00).
REQ-026 zero SHALL be combinational from the digit registers.
REQ-027 A run change SHALL take effect on the same edge; events coinciding with a run edge SHALL follow the new value of run.
REQ-028 Latency from an event edge to updated digits SHALL be 0 cycles; events are evaluated on the edge where they are detected.

Reset
REQ-029 rst=1 at a clock edge SHALL set digits=0, loadn_q=1, tick_q=0 and done=0, overriding every event in that cycle.
REQ-030 After rst the outputs SHALL be 00:00, zero=1, done=0.
REQ-031 Reset during a countdown SHALL abort it without a done pulse.
REQ-032 No state SHALL depend on an initial value without rst.

Verification
REQ-033 Bench: run=0, enter keys 1,2,3,0 (each a loadn low pulse of 3 cycles) -> digits 12:30, zero=0.
REQ-034 Bench: 00:01, run=1, one pgt_1Hz rising edge -> 00:00, zero=1, done high one cycle; further ticks -> still 00:00, done=0.
REQ-035 Bench: 10:00, run=1, one tick -> 09:59; then 00:90, one tick -> 00:89.
REQ-036 Bench: loadn held low for 50 cycles with D=7 -> exactly one shift; D=12 pulse -> digits unchanged.
REQ-037 Bench: run=1 with key_evt and tick_evt on the same edge -> one-second decrement only, no shift.
REQ-038 Bench: rst asserted mid-countdown at 05:17 -> next edge 00:00, zero=1, no done pulse.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Keypad/tick inputs and MM:SS BCD outputs of the countdown timer, bundled as one port.
// The master drives keypad, tick and mode; the slave (timer) drives digits, zero and done.
interface countdown_timer_if;
    logic [3:0] D;
    logic       loadn;
    logic       pgt_1Hz;
    logic       run;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       zero;
    logic       done;

    modport master (
        output D, loadn, pgt_1Hz, run,
        input  sec_ones, sec_tens, min_ones, min_tens, zero, done
    );

    modport slave (
        input  D, loadn, pgt_1Hz, run,
        output sec_ones, sec_tens, min_ones, min_tens, zero, done
    );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer: keypad digits shift in while idle, 1 Hz ticks count down while running.
// Digits update on the same edge an event is detected; done follows one edge after 00:00 is reached.
module countdown_timer (
    input  logic                    clk,
    input  logic                    rst,
    countdown_timer_if.slave        tif
);

    logic [3:0] sec_ones_q, sec_tens_q, min_ones_q, min_tens_q;
    logic [3:0] sec_ones_d, sec_tens_d, min_ones_d, min_tens_d;
    logic       loadn_q;
    logic       tick_q;
    logic       hit_zero_q, hit_zero_d;
    logic       done_q;
    logic       key_evt;
    logic       tick_evt;
    logic       zero;
    logic       dec_en;

    assign key_evt  = !tif.loadn && loadn_q;
    assign tick_evt = tif.pgt_1Hz && !tick_q;
    assign zero     = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0) &&
                      (min_ones_q == 4'd0) && (min_tens_q == 4'd0);
    assign dec_en   = tif.run && tick_evt && !zero;

    always_comb begin
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        if (dec_en) begin
            // Borrow chain; sec_tens entered as 6-9 is decremented as-is, never normalised.
            if (sec_ones_q != 4'd0) begin
                sec_ones_d = sec_ones_q - 4'd1;
            end else begin
                sec_ones_d = 4'd9;
                if (sec_tens_q != 4'd0) begin
                    sec_tens_d = sec_tens_q - 4'd1;
                end else begin
                    sec_tens_d = 4'd5;
                    if (min_ones_q != 4'd0) begin
                        min_ones_d = min_ones_q - 4'd1;
                    end else begin
                        min_ones_d = 4'd9;
                        min_tens_d = min_tens_q - 4'd1;
                    end
                end
            end
        end else if (!tif.run && key_evt && (tif.D <= 4'd9)) begin
            min_tens_d = min_ones_q;
            min_ones_d = sec_tens_q;
            sec_tens_d = sec_ones_q;
            sec_ones_d = tif.D;
        end
    end

    assign hit_zero_d = dec_en && (sec_ones_d == 4'd0) && (sec_tens_d == 4'd0) &&
                        (min_ones_d == 4'd0) && (min_tens_d == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            loadn_q    <= 1'b1;
            tick_q     <= 1'b0;
            hit_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            loadn_q    <= tif.loadn;
            tick_q     <= tif.pgt_1Hz;
            hit_zero_q <= hit_zero_d;
            done_q     <= hit_zero_q;
        end
    end

    assign tif.sec_ones = sec_ones_q;
    assign tif.sec_tens = sec_tens_q;
    assign tif.min_ones = min_ones_q;
    assign tif.min_tens = min_tens_q;
    assign tif.zero     = zero;
    assign tif.done     = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a per-cycle vector table plus hand-written corner sequences.
module tb_countdown_timer;

    logic clk = 1'b0;
    logic rst;

    countdown_timer_if tif ();

    countdown_timer dut (
        .clk (clk),
        .rst (rst),
        .tif (tif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        run;
        logic        loadn;
        logic        pgt;
        logic [3:0]  d;
        logic [15:0] exp_time;
        logic        exp_zero;
        logic        exp_done;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(input logic r, input logic rn, input logic ld, input logic pg,
                                input logic [3:0] d, input logic [15:0] t, input logic z,
                                input logic dn);
        vec_t v;
        v.rst = r; v.run = rn; v.loadn = ld; v.pgt = pg; v.d = d;
        v.exp_time = t; v.exp_zero = z; v.exp_done = dn;
        vecs.push_back(v);
    endfunction

    // One keypress in entry mode: three low cycles then one high cycle.
    function automatic void add_key(input logic [3:0] d, input logic [15:0] t);
        add(0, 0, 0, 0, d, t, 0, 0);
        add(0, 0, 0, 0, d, t, 0, 0);
        add(0, 0, 0, 0, d, t, 0, 0);
        add(0, 0, 1, 0, d, t, 0, 0);
    endfunction

    function automatic logic [15:0] digits();
        return {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones};
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic press(input logic [3:0] d);
        tif.run   = 1'b0;
        tif.D     = d;
        tif.loadn = 1'b0;
        repeat (3) step();
        tif.loadn = 1'b1;
        step();
    endtask

    initial begin
        rst         = 1'b1;
        tif.D       = 4'd0;
        tif.loadn   = 1'b1;
        tif.pgt_1Hz = 1'b0;
        tif.run     = 1'b0;

        // rst run loadn pgt D  time  zero done
        add(1, 0, 1, 0, 0, 16'h0000, 1, 0);
        add(0, 0, 1, 0, 0, 16'h0000, 1, 0);
        add_key(4'd1, 16'h0001);
        add_key(4'd2, 16'h0012);
        add_key(4'd3, 16'h0123);
        add_key(4'd0, 16'h1230);
        add(0, 0, 0, 0, 12, 16'h1230, 0, 0);
        add(0, 0, 1, 0, 12, 16'h1230, 0, 0);
        // Key and tick on the same edge in count mode: decrement only.
        add(0, 1, 0, 1, 5, 16'h1229, 0, 0);
        add(0, 1, 1, 0, 5, 16'h1229, 0, 0);
        add(0, 1, 0, 0, 4, 16'h1229, 0, 0);
        add(0, 1, 1, 0, 4, 16'h1229, 0, 0);
        // 00:01 to 00:00, done one edge later, then ticks hold at zero.
        add(1, 0, 1, 0, 0, 16'h0000, 1, 0);
        add(0, 0, 0, 0, 1, 16'h0001, 0, 0);
        add(0, 0, 1, 0, 1, 16'h0001, 0, 0);
        add(0, 0, 1, 1, 1, 16'h0001, 0, 0);
        add(0, 0, 1, 0, 1, 16'h0001, 0, 0);
        add(0, 1, 1, 1, 1, 16'h0000, 1, 0);
        add(0, 1, 1, 1, 1, 16'h0000, 1, 1);
        add(0, 1, 1, 0, 1, 16'h0000, 1, 0);
        add(0, 1, 1, 1, 1, 16'h0000, 1, 0);
        add(0, 1, 1, 0, 1, 16'h0000, 1, 0);
        add(0, 1, 1, 1, 1, 16'h0000, 1, 0);
        add(0, 1, 1, 0, 1, 16'h0000, 1, 0);

        step();
        foreach (vecs[i]) begin
            rst         = vecs[i].rst;
            tif.run     = vecs[i].run;
            tif.loadn   = vecs[i].loadn;
            tif.pgt_1Hz = vecs[i].pgt;
            tif.D       = vecs[i].d;
            step();
            chk($sformatf("vec%0d_time", i), digits(), vecs[i].exp_time);
            chk($sformatf("vec%0d_zero", i), {15'd0, tif.zero}, {15'd0, vecs[i].exp_zero});
            chk($sformatf("vec%0d_done", i), {15'd0, tif.done}, {15'd0, vecs[i].exp_done});
        end
        rst = 1'b0; tif.run = 1'b0; tif.loadn = 1'b1; tif.pgt_1Hz = 1'b0;
        step();

        // Long key hold loads once; release re-arms.
        do_reset();
        tif.D = 4'd7;
        tif.loadn = 1'b0;
        step();
        chk("hold_first", digits(), 16'h0007);
        repeat (49) step();
        chk("hold_50", digits(), 16'h0007);
        tif.loadn = 1'b1;
        step();
        tif.loadn = 1'b0;
        step();
        chk("hold_rearm", digits(), 16'h0077);
        tif.loadn = 1'b1;
        step();

        // 10:00 -> 09:59 full borrow chain.
        do_reset();
        press(4'd1); press(4'd0); press(4'd0); press(4'd0);
        chk("load_1000", digits(), 16'h1000);
        tif.run = 1'b1;
        tif.pgt_1Hz = 1'b1;
        step();
        chk("dec_1000", digits(), 16'h0959);
        tif.pgt_1Hz = 1'b0;
        step();

        // Unnormalised seconds tens: 00:90 -> 00:89.
        do_reset();
        press(4'd9); press(4'd0);
        chk("load_0090", digits(), 16'h0090);
        tif.run = 1'b1;
        tif.pgt_1Hz = 1'b1;
        step();
        chk("dec_0090", digits(), 16'h0089);
        tif.pgt_1Hz = 1'b0;
        step();

        // Reset mid-countdown at 05:17, coinciding with a tick.
        do_reset();
        press(4'd0); press(4'd5); press(4'd1); press(4'd7);
        chk("load_0517", digits(), 16'h0517);
        tif.run = 1'b1;
        tif.pgt_1Hz = 1'b1;
        rst = 1'b1;
        step();
        chk("rst_time", digits(), 16'h0000);
        chk("rst_zero", {15'd0, tif.zero}, 16'd1);
        chk("rst_done", {15'd0, tif.done}, 16'd0);
        rst = 1'b0;
        tif.pgt_1Hz = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rst_nodone%0d", k), {15'd0, tif.done}, 16'd0);
        end

        // Reset on the edge after reaching 00:00 suppresses the done pulse.
        do_reset();
        press(4'd1);
        tif.run = 1'b1;
        tif.pgt_1Hz = 1'b1;
        step();
        chk("z_reach", digits(), 16'h0000);
        tif.pgt_1Hz = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("z_rst_done", {15'd0, tif.done}, 16'd0);
        step();
        chk("z_rst_done2", {15'd0, tif.done}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
